ant_world: RTL and testbench

Environment model for the ant maze: the counterpart that consumes the controller's `move` each cycle and produces the `ant_l`, `ant_r`, `hit` and `escape` sensor signals. It holds a loadable wall map, the ant's position and heading, a step counter and a run FSM. Testbenches and the FPGA demo use it in closed loop with the ant controller.

---
 rtl/ant_world.sv | 195 +++++++++++++++++++
 tb/tb_ant_world.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_world.sv
// ant_world: maze environment for the ant controller (wall map, ant pose, step budget, run FSM).
// Optional pheromone layer (ph_drop / ph_detected) is built when WORLD_PHEROMONE_EN is defined.
`ifndef HALT
`define HALT    2'd0
`endif
`ifndef RIGHT
`define RIGHT   2'd1
`endif
`ifndef LEFT
`define LEFT    2'd2
`endif
`ifndef FORWARD
`define FORWARD 2'd3
`endif

module ant_world #(
  parameter int MAP_W     = 8,
  parameter int MAP_H     = 8,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int START_DIR = 1,
  parameter int EXIT_X    = 7,
  parameter int EXIT_Y    = 7,
  parameter int MAX_STEPS = 1000,
  parameter int PH_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     map_we,
  input  logic [$clog2(MAP_W)-1:0] map_x,
  input  logic [$clog2(MAP_H)-1:0] map_y,
  input  logic                     map_wall,
  input  logic                     start,
  input  logic [1:0]               move,
`ifdef WORLD_PHEROMONE_EN
  input  logic [PH_WIDTH-1:0]      ph_drop,
  output logic [PH_WIDTH-1:0]      ph_detected,
`endif
  output logic                     ant_l,
  output logic                     ant_r,
  output logic                     hit,
  output logic                     escape,
  output logic                     timeout,
  output logic [15:0]              steps,
  output logic [$clog2(MAP_W)-1:0] pos_x,
  output logic [$clog2(MAP_H)-1:0] pos_y,
  output logic [1:0]               dir
);

  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XW-1:0] SX    = XW'(START_X);
  localparam logic [YW-1:0] SY    = YW'(START_Y);
  localparam logic [1:0]    SD    = 2'(START_DIR);
  localparam logic [XW-1:0] EX    = XW'(EXIT_X);
  localparam logic [YW-1:0] EY    = YW'(EXIT_Y);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam logic [XW-1:0] X_MAX = XW'(MAP_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MAP_H - 1);

  logic [1:0] state;
  logic       map_q [MAP_H][MAP_W];

  // Neighbour of (x,y) in heading d, packed as {out_of_grid, y, x}.
  // An out-of-grid neighbour returns the current cell so map lookups stay in range.
  function automatic logic [XW+YW:0] neighbor(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y,
                                              input logic [1:0]    d);
    logic          oob;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    oob = 1'b0;
    nx  = x;
    ny  = y;
    case (d)
      2'd0:    if (y == '0)    oob = 1'b1; else ny = y - Y_ONE;
      2'd1:    if (x == X_MAX) oob = 1'b1; else nx = x + X_ONE;
      2'd2:    if (y == Y_MAX) oob = 1'b1; else ny = y + Y_ONE;
      default: if (x == '0)    oob = 1'b1; else nx = x - X_ONE;
    endcase
    return {oob, ny, nx};
  endfunction

  logic          ah_oob, lf_oob, ah_wall, lf_wall, at_exit, wr_ok;
  logic [XW-1:0] ah_x, lf_x;
  logic [YW-1:0] ah_y, lf_y;

  always_comb begin
    {ah_oob, ah_y, ah_x} = neighbor(pos_x, pos_y, dir);
    {lf_oob, lf_y, lf_x} = neighbor(pos_x, pos_y, dir + 2'd3);
    ah_wall = ah_oob | map_q[ah_y][ah_x];
    lf_wall = lf_oob | map_q[lf_y][lf_x];
  end

  assign at_exit = (pos_x == EX) && (pos_y == EY);
  assign wr_ok   = (int'(map_x) < MAP_W) && (int'(map_y) < MAP_H) &&
                   !((map_x == SX) && (map_y == SY)) &&
                   !((map_x == EX) && (map_y == EY));

  // Sensors depend only on registered pose and map, never on move.
  assign ant_r  = (state != S_IDLE) && ah_wall;
  assign ant_l  = (state != S_IDLE) && lf_wall;
  assign escape = (state != S_IDLE) && at_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pos_x   <= SX;
      pos_y   <= SY;
      dir     <= SD;
      hit     <= 1'b0;
      timeout <= 1'b0;
      steps   <= '0;
      for (int yy = 0; yy < MAP_H; yy++)
        for (int xx = 0; xx < MAP_W; xx++)
          map_q[yy][xx] <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          // Exit is checked before the budget so a simultaneous finish counts as an escape.
          if (at_exit) begin
            state   <= S_DONE;
            timeout <= 1'b0;
          end else if (int'(steps) >= MAX_STEPS) begin
            state   <= S_DONE;
            timeout <= 1'b1;
          end else begin
            if ((move != `HALT) && (steps != 16'hFFFF))
              steps <= steps + 16'd1;
            case (move)
              `RIGHT: begin
                dir <= dir + 2'd1;
                hit <= 1'b0;
              end
              `LEFT: begin
                dir <= dir + 2'd3;
                hit <= 1'b0;
              end
              `FORWARD: begin
                if (ah_wall) begin
                  hit <= 1'b1;
                end else begin
                  pos_x <= ah_x;
                  pos_y <= ah_y;
                  hit   <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        default: begin
          if (map_we && wr_ok)
            map_q[map_y][map_x] <= map_wall;
          if (start) begin
            state   <= S_RUN;
            pos_x   <= SX;
            pos_y   <= SY;
            dir     <= SD;
            hit     <= 1'b0;
            timeout <= 1'b0;
            steps   <= '0;
          end
        end
      endcase
    end
  end

`ifdef WORLD_PHEROMONE_EN
  logic [PH_WIDTH-1:0] ph_q [MAP_H][MAP_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int yy = 0; yy < MAP_H; yy++)
        for (int xx = 0; xx < MAP_W; xx++)
          ph_q[yy][xx] <= '0;
    end else if ((state != S_RUN) && start) begin
      for (int yy = 0; yy < MAP_H; yy++)
        for (int xx = 0; xx < MAP_W; xx++)
          ph_q[yy][xx] <= '0;
    end else if ((state == S_RUN) && (ph_drop != '0)) begin
      ph_q[pos_y][pos_x] <= ph_drop;
    end
  end

  assign ph_detected = ah_wall ? '0 : ph_q[ah_y][ah_x];
`endif

endmodule

// File: tb/tb_ant_world.sv
// Scoreboard bench for ant_world: stimulus pushes hand-computed poses/sensors, a negedge monitor checks them.
`ifndef HALT
`define HALT    2'd0
`endif
`ifndef RIGHT
`define RIGHT   2'd1
`endif
`ifndef LEFT
`define LEFT    2'd2
`endif
`ifndef FORWARD
`define FORWARD 2'd3
`endif

module tb_ant_world;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        map_we = 1'b0;
  logic [2:0]  map_x = '0, map_y = '0;
  logic        map_wall = 1'b0;
  logic        start = 1'b0, start4 = 1'b0;
  logic [1:0]  move = `HALT, move4 = `HALT;
  logic [1:0]  ph_drop = '0;

  logic        ant_l, ant_r, hit, escape, timeout;
  logic [15:0] steps;
  logic [2:0]  pos_x, pos_y;
  logic [1:0]  dir;
  logic        ant_l4, ant_r4, hit4, escape4, timeout4;
  logic [15:0] steps4;
  logic [2:0]  pos_x4, pos_y4;
  logic [1:0]  dir4;
`ifdef WORLD_PHEROMONE_EN
  logic [1:0]  ph_drop4 = '0;
  logic [1:0]  ph_det, ph_det4;
`endif

  always #5 clk = ~clk;

  ant_world dut (
    .clk(clk), .rst_n(rst_n), .map_we(map_we), .map_x(map_x), .map_y(map_y),
    .map_wall(map_wall), .start(start), .move(move),
`ifdef WORLD_PHEROMONE_EN
    .ph_drop(ph_drop), .ph_detected(ph_det),
`endif
    .ant_l(ant_l), .ant_r(ant_r), .hit(hit), .escape(escape), .timeout(timeout),
    .steps(steps), .pos_x(pos_x), .pos_y(pos_y), .dir(dir)
  );

  ant_world #(.START_DIR(0), .MAX_STEPS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .map_we(map_we), .map_x(map_x), .map_y(map_y),
    .map_wall(map_wall), .start(start4), .move(move4),
`ifdef WORLD_PHEROMONE_EN
    .ph_drop(ph_drop4), .ph_detected(ph_det4),
`endif
    .ant_l(ant_l4), .ant_r(ant_r4), .hit(hit4), .escape(escape4), .timeout(timeout4),
    .steps(steps4), .pos_x(pos_x4), .pos_y(pos_y4), .dir(dir4)
  );

  typedef struct {
    string       name;
    bit          sel;
    logic [28:0] exp;
    logic [1:0]  ph;
  } rec_t;

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic string fmt(input logic [28:0] v);
    return $sformatf("x=%0d y=%0d dir=%0d l=%0b r=%0b hit=%0b esc=%0b to=%0b steps=%0d",
                     v[28:26], v[25:23], v[22:21], v[20], v[19], v[18], v[17], v[16], v[15:0]);
  endfunction

  // Monitor: everything queued since the last edge is checked mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      rec_t        r;
      logic [28:0] got;
      r = sb.pop_front();
      got = r.sel ? {pos_x4, pos_y4, dir4, ant_l4, ant_r4, hit4, escape4, timeout4, steps4}
                  : {pos_x, pos_y, dir, ant_l, ant_r, hit, escape, timeout, steps};
      n_cmp++;
      if (got !== r.exp) begin
        n_bad++;
        $display("FAIL %s: got %s, required %s", r.name, fmt(got), fmt(r.exp));
      end
`ifdef WORLD_PHEROMONE_EN
      begin
        logic [1:0] gph;
        gph = r.sel ? ph_det4 : ph_det;
        n_cmp++;
        if (gph !== r.ph) begin
          n_bad++;
          $display("FAIL %s ph_detected: got %0d, required %0d", r.name, gph, r.ph);
        end
      end
`endif
    end
  end

  task automatic exp_s(input string nm, input bit sel, input int x, input int y, input int d,
                       input bit l, input bit r, input bit h, input bit e, input bit t,
                       input int s, input int ph = 0);
    rec_t rr;
    rr.name = nm;
    rr.sel  = sel;
    rr.exp  = {3'(x), 3'(y), 2'(d), l, r, h, e, t, 16'(s)};
    rr.ph   = 2'(ph);
    sb.push_back(rr);
  endtask

  task automatic step(input logic [1:0] m, input bit st = 1'b0, input logic [1:0] drop = 2'd0);
    @(negedge clk);
    move    = m;
    start   = st;
    ph_drop = drop;
    @(posedge clk);
    #1;
    move    = `HALT;
    start   = 1'b0;
    ph_drop = '0;
  endtask

  task automatic step4(input logic [1:0] m, input bit st = 1'b0);
    @(negedge clk);
    move4  = m;
    start4 = st;
    @(posedge clk);
    #1;
    move4  = `HALT;
    start4 = 1'b0;
  endtask

  task automatic map_write(input int x, input int y, input bit w);
    @(negedge clk);
    map_we   = 1'b1;
    map_x    = 3'(x);
    map_y    = 3'(y);
    map_wall = w;
    @(posedge clk);
    #1;
    map_we   = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_s(nm, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    exp_s(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset");

    // Exit and start cells must stay free even when written while idle.
    map_write(7, 7, 1'b1);
    map_write(0, 0, 1'b1);

    step(`HALT, 1'b1);
    exp_s("start", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step(`FORWARD);
      exp_s("fwd_east", 0, k, 0, 1, 1, (k == 7), 0, 0, 0, k);
    end
    step(`RIGHT);
    exp_s("turn_south", 0, 7, 0, 2, 1, 0, 0, 0, 0, 8);
    for (int k = 1; k <= 7; k++) begin
      step(`FORWARD);
      exp_s("fwd_south", 0, 7, k, 2, 1, (k == 7), 0, (k == 7), 0, 8 + k);
    end
    step(`HALT);
    exp_s("done_hold", 0, 7, 7, 2, 1, 1, 0, 1, 0, 15);
    step(`FORWARD);
    exp_s("done_frozen", 0, 7, 7, 2, 1, 1, 0, 1, 0, 15);

    map_write(0, 0, 1'b1);
    map_write(1, 0, 1'b1);
    step(`HALT, 1'b1);
    exp_s("start2", 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    step(`FORWARD);
    exp_s("blocked", 0, 0, 0, 1, 1, 1, 1, 0, 0, 1);
    step(`RIGHT);
    exp_s("turn_after_hit", 0, 0, 0, 2, 1, 0, 0, 0, 0, 2);
    map_write(0, 1, 1'b1);
    exp_s("run_write_ignored", 0, 0, 0, 2, 1, 0, 0, 0, 0, 2);
    step(`FORWARD);
    exp_s("fwd_south2", 0, 0, 1, 2, 0, 0, 0, 0, 0, 3);
    step(`LEFT);
    exp_s("start_cell_free", 0, 0, 1, 1, 0, 0, 0, 0, 0, 4);

    do_reset("reset_mid");
    step(`HALT, 1'b1);
    exp_s("map_cleared", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

    step(`FORWARD);
    exp_s("ph_fwd1", 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    step(`FORWARD, 1'b1);
    exp_s("start_ignored", 0, 2, 0, 1, 1, 0, 0, 0, 0, 2, 0);
    step(`LEFT, 1'b0, 2'd2);
    exp_s("ph_drop_left", 0, 2, 0, 0, 0, 1, 0, 0, 0, 3, 0);
    step(`LEFT);
    exp_s("ph_face_west", 0, 2, 0, 3, 0, 0, 0, 0, 0, 4, 0);
    step(`FORWARD);
    exp_s("ph_fwd_west", 0, 1, 0, 3, 0, 0, 0, 0, 0, 5, 0);
    step(`LEFT);
    exp_s("ph_face_south", 0, 1, 0, 2, 0, 0, 0, 0, 0, 6, 0);
    step(`LEFT);
    exp_s("ph_face_drop", 0, 1, 0, 1, 1, 0, 0, 0, 0, 7, 2);

    step4(`HALT, 1'b1);
    exp_s("north_start", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step4(`LEFT);
    exp_s("budget_l1", 1, 0, 0, 3, 0, 1, 0, 0, 0, 1);
    step4(`LEFT);
    exp_s("budget_l2", 1, 0, 0, 2, 0, 0, 0, 0, 0, 2);
    step4(`LEFT);
    exp_s("budget_l3", 1, 0, 0, 1, 1, 0, 0, 0, 0, 3);
    step4(`LEFT);
    exp_s("budget_l4", 1, 0, 0, 0, 1, 1, 0, 0, 0, 4);
    step4(`FORWARD);
    exp_s("timeout", 1, 0, 0, 0, 1, 1, 0, 0, 1, 4);
    step4(`FORWARD);
    exp_s("timeout_frozen", 1, 0, 0, 0, 1, 1, 0, 0, 1, 4);

    @(negedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
